// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: drives one row low at a time, synchronizes the
// columns, debounces press and release, and strobes one hex code per press.
module keypad_scan_debounce #(
  parameter int SCAN_DIV     = 48000,
  parameter int DEBOUNCE_CNT = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols_n,
  output logic [3:0] rows_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [3:0]    sync1, cols_s;
  logic [DW-1:0] dwell, dwell_next;
  logic [CW-1:0] db_cnt, db_next;
  logic [1:0]    row, row_next;
  logic [1:0]    col, col_next;
  logic [1:0]    first_low;
  logic          col_low;
  logic          valid_next;
  logic          held_next;
  logic [3:0]    code_next;

  // Key legend: row 3 carries '*' as E and '#' as F.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 4'hF;
      cols_s <= 4'hF;
    end else begin
      sync1  <= cols_n;
      cols_s <= sync1;
    end
  end

  // Lowest-index active column wins when several keys share the row.
  always_comb begin
    first_low = 2'd3;
    if (!cols_s[0])      first_low = 2'd0;
    else if (!cols_s[1]) first_low = 2'd1;
    else if (!cols_s[2]) first_low = 2'd2;
  end

  assign col_low = ~cols_s[col];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      dwell     <= '0;
      db_cnt    <= '0;
      row       <= 2'd0;
      col       <= 2'd0;
      rows_n    <= 4'b1110;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_next;
      dwell     <= dwell_next;
      db_cnt    <= db_next;
      row       <= row_next;
      col       <= col_next;
      rows_n    <= ~(4'b0001 << row_next);
      key_valid <= valid_next;
      key_code  <= code_next;
      key_held  <= held_next;
    end
  end

  always_comb begin
    state_next = state;
    dwell_next = dwell;
    db_next    = db_cnt;
    row_next   = row;
    col_next   = col;
    valid_next = 1'b0;
    code_next  = key_code;
    held_next  = key_held;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_next = '0;
          if (cols_s == 4'hF) begin
            row_next = row + 2'd1;
          end else begin
            col_next   = first_low;
            db_next    = '0;
            state_next = DEBOUNCE;
          end
        end else begin
          dwell_next = dwell + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (col_low) begin
          if (db_cnt == DB_LAST) begin
            state_next = HELD;
            valid_next = 1'b1;
            code_next  = key_map(row, col);
            held_next  = 1'b1;
            db_next    = '0;
          end else begin
            db_next = db_cnt + CW'(1);
          end
        end else begin
          state_next = SCAN;
          db_next    = '0;
          dwell_next = '0;
          row_next   = row + 2'd1;
        end
      end
      HELD: begin
        // Other columns are ignored until this key is released.
        if (!col_low) begin
          db_next    = '0;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!col_low) begin
          if (db_cnt == DB_LAST) begin
            state_next = SCAN;
            held_next  = 1'b0;
            db_next    = '0;
            dwell_next = '0;
            row_next   = row + 2'd1;
          end else begin
            db_next = db_cnt + CW'(1);
          end
        end else begin
          state_next = HELD;
          db_next    = '0;
        end
      end
      default: begin
        state_next = SCAN;
      end
    endcase
  end

  a_one_row: assert property (@(posedge clk) disable iff (reset) $onehot(~rows_n));
  a_single_strobe: assert property (@(posedge clk) disable iff (reset) key_valid |=> !key_valid);
  a_strobe_held: assert property (@(posedge clk) disable iff (reset) key_valid |-> key_held);

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Drives the rows of a 4x4 matrix keypad one at a time and samples the columns through an internal 2-flop synchronizer.
- Debounces both press and release of a key.
- Emits exactly one single-cycle key_valid strobe with a 4-bit hex key_code per physical press.
- Sits between the keypad pins and the two-digit seven-segment display path, which consumes key_code on each key_valid.

Parameters:
- SCAN_DIV, 48000: clk cycles each row is driven before advancing (1 ms at 48 MHz); must be >= 4.
- DEBOUNCE_CNT, 960000: consecutive stable clk cycles required to accept a press or a release (20 ms at 48 MHz); must be >= 2.

Ports:
- clk  input  1  system clock (48 MHz HSOSC).
- reset  input  1  reset, synchronous, active-high.
- cols_n  input  4  raw asynchronous keypad columns, active-low, pulled up.
- rows_n  output  4  keypad row drive, active-low, exactly one bit low at all times.
- key_valid  output  1  one-cycle strobe, new debounced key accepted.
- key_code  output  4  hex code of last accepted key; stable between strobes.
- key_held  output  1  high from key_valid until release debounce completes.

Behaviour:
- Reset values: rows_n=4'b1110 (row 0), key_valid=0, key_code=4'h0, key_held=0, state=SCAN, all counters 0, synchronizer flops 4'b1111.
- Synchronizer: cols_s = cols_n delayed two clk; all decisions use cols_s only.
- Key map (row,col → code):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D (* = E, # = F)
- State SCAN:
  - dwell counter counts 0..SCAN_DIV-1 on the current row; cols_s is sampled only on the dwell==SCAN_DIV-1 cycle.
  - If the sample is 4'b1111, advance the row (3 wraps to 0) and clear dwell.
  - Otherwise latch row and lowest-index low column (priority col0 > col3), hold the row, clear the debounce counter, and go to DEBOUNCE.
- State DEBOUNCE:
  - Each cycle the latched column must read 0. If it does, increment db_cnt; if not, go to SCAN, clear db_cnt, and advance to the next row.
  - When db_cnt==DEBOUNCE_CNT-1 and the column still reads 0, the next cycle key_valid=1 for one cycle, key_code updates in the same cycle, key_held=1, and the state goes to HELD.
- State HELD:
  - Row stays driven; only the latched column is watched, so other keys are ignored.
  - The latched column reading 1 clears db_cnt and goes to RELEASE.
- State RELEASE:
  - The latched column must read 1 for DEBOUNCE_CNT consecutive cycles; then key_held=0, go to SCAN, and advance to the next row.
  - The column reading 0 at any point returns to HELD with no new strobe.
- key_valid is never high on two consecutive cycles; at most one strobe per SCAN→HELD traversal.
- Reset asserted in any state returns to the reset values on the next clk edge, including mid-debounce; no strobe is produced.
- Counter widths are $clog2(param); no counter wraps, since each is cleared on every state exit.

Test Plan:
(Bench overrides: SCAN_DIV=8, DEBOUNCE_CNT=16.)
- Reset: hold reset 3 cycles, cols_n=4'hF → rows_n=4'b1110, key_valid=0, key_code=0, key_held=0; rows_n steps 1110→1101→1011→0111→1110 every 8 cycles.
- Clean press '5': model pulls col1 low only while row1 is driven, held 100 cycles → exactly one key_valid, key_code=4'h5, key_held=1; after release plus 16 stable cycles, key_held=0 and scanning resumes at row2.
- Bounce rejection: col2 on row0 low for 10 cycles then high → no key_valid, FSM back in SCAN; a later 40-cycle press on the same key → one strobe, key_code=4'h3.
- Release bounce: hold '0' (row3,col1), then toggle col1 high/low every 5 cycles for 30 cycles, then high → single strobe key_code=4'h0, key_held stays 1 through the bounce, no second strobe.
- Multiple keys: row2 with col0 and col3 low together → key_code=4'h7; pressing 'A' while '7' is held → no strobe.
- Reset mid-operation: assert reset at DEBOUNCE db_cnt=10 → next cycle shows reset values; no key_valid for that press.
